// File: rtl/seq_pkg.sv
// Shared types and helpers for the drum pattern step sequencer.
package seq_pkg;

    localparam int unsigned NUM_VOICES = 4;
    localparam int unsigned NUM_STEPS  = 8;
    localparam int unsigned STEP_W     = 3;
    localparam int unsigned PAT_W      = NUM_VOICES * NUM_STEPS;

    typedef enum logic [0:0] {
        StStopped,
        StRunning
    } seq_state_t;

    // Voice column for one step: bit v of the result is pattern bit 8*v+step.
    function automatic logic [NUM_VOICES-1:0] pat_col(input logic [PAT_W-1:0]  pat,
                                                      input logic [STEP_W-1:0] step);
        logic [NUM_VOICES-1:0] col;
        col = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            col[v] = pat[v * NUM_STEPS + int'(step)];
        end
        return col;
    endfunction

endpackage

// File: rtl/tempo_tick_gen.sv
// Sixteenth-note tick source: clamped BPM added into a phase accumulator each cycle.
module tempo_tick_gen #(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned BPM_MIN = 40,
    parameter int unsigned BPM_MAX = 240
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       enable_i,
    input  logic [7:0] tempo_bpm_i,
    output logic       tick_o
);

    localparam int unsigned THRESH = CLK_HZ * 15;
    localparam int unsigned ACC_W  = $clog2(THRESH + BPM_MAX);

    logic [7:0]       bpm_c;
    logic [ACC_W-1:0] acc_d, acc_q;
    logic [ACC_W-1:0] sum;

    // Clamp tempo, add, and wrap on threshold; the remainder carries so there is no drift.
    always_comb begin
        bpm_c = tempo_bpm_i;
        if ({24'd0, tempo_bpm_i} < BPM_MIN) begin
            bpm_c = BPM_MIN[7:0];
        end else if ({24'd0, tempo_bpm_i} > BPM_MAX) begin
            bpm_c = BPM_MAX[7:0];
        end
        sum    = acc_q + ACC_W'(bpm_c);
        tick_o = enable_i && (sum >= ACC_W'(THRESH));
        if (!enable_i) begin
            acc_d = '0;
        end else if (tick_o) begin
            acc_d = sum - ACC_W'(THRESH);
        end else begin
            acc_d = sum;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/pattern_step_sequencer.sv
// 4-voice x 8-step drum sequencer; pattern updates are held back until the bar wraps.
module pattern_step_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned BPM_MIN = 40,
    parameter int unsigned BPM_MAX = 240
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic [31:0] pattern_new_signal,
    input  logic [7:0]  tempo_bpm,
    input  logic        run,
    output logic [3:0]  voice_trig,
    output logic [2:0]  step_idx,
    output logic [7:0]  step_onehot,
    output logic        bar_start,
    output logic        pattern_pending
);

    seq_state_t state_d, state_q;

    logic [STEP_W-1:0]     step_d, step_q;
    logic [NUM_STEPS-1:0]  onehot_d, onehot_q;
    logic [PAT_W-1:0]      active_d, active_q;
    logic [PAT_W-1:0]      shadow_d, shadow_q;
    logic [PAT_W-1:0]      next_pat_d, next_pat_q;
    logic                  chg_d, chg_q;
    logic                  pending_d, pending_q;
    logic [NUM_VOICES-1:0] trig_d, trig_q;
    logic                  bar_d, bar_q;
    logic                  tick;
    logic                  run_go;

    // Accumulator only advances while running and run is still asserted.
    assign run_go = (state_q == StRunning) && run;

    tempo_tick_gen #(
        .CLK_HZ  (CLK_HZ),
        .BPM_MIN (BPM_MIN),
        .BPM_MAX (BPM_MAX)
    ) u_tick (
        .clk_i       (clk_clk),
        .rst_ni      (reset_reset_n),
        .enable_i    (run_go),
        .tempo_bpm_i (tempo_bpm),
        .tick_o      (tick)
    );

    // State register.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q <= StStopped;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state follows the run level directly.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StStopped: if (run)  state_d = StRunning;
            StRunning: if (!run) state_d = StStopped;
            default:             state_d = StStopped;
        endcase
    end

    // Pattern capture, step advance and trigger generation.
    always_comb begin
        shadow_d   = pattern_new_signal;
        chg_d      = (pattern_new_signal != shadow_q);
        step_d     = step_q;
        active_d   = active_q;
        next_pat_d = next_pat_q;
        pending_d  = pending_q;
        trig_d     = '0;
        bar_d      = 1'b0;
        unique case (state_q)
            StStopped: begin
                step_d = '0;
                // No bar to protect while stopped: apply changes immediately.
                if (pending_q) begin
                    active_d  = next_pat_q;
                    pending_d = 1'b0;
                end
                if (chg_q) begin
                    active_d = shadow_q;
                end
                if (run) begin
                    trig_d = pat_col(active_d, '0);
                    bar_d  = 1'b1;
                end
            end
            StRunning: begin
                if (chg_q) begin
                    pending_d  = 1'b1;
                    next_pat_d = shadow_q;
                end
                if (!run) begin
                    step_d = '0;
                end else if (tick) begin
                    step_d = step_q + 3'd1;
                    if (step_q == 3'(NUM_STEPS - 1)) begin
                        // Swap before evaluating step 0; a change landing now waits a bar.
                        if (pending_q) begin
                            active_d = next_pat_q;
                        end
                        if (!chg_q) begin
                            pending_d = 1'b0;
                        end
                        bar_d = 1'b1;
                    end
                    trig_d = pat_col(active_d, step_d);
                end
            end
            default: step_d = '0;
        endcase
        onehot_d = 8'h01 << step_d;
    end

    // Datapath and output registers.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            step_q     <= '0;
            onehot_q   <= 8'h01;
            active_q   <= '0;
            shadow_q   <= '0;
            next_pat_q <= '0;
            chg_q      <= 1'b0;
            pending_q  <= 1'b0;
            trig_q     <= '0;
            bar_q      <= 1'b0;
        end else begin
            step_q     <= step_d;
            onehot_q   <= onehot_d;
            active_q   <= active_d;
            shadow_q   <= shadow_d;
            next_pat_q <= next_pat_d;
            chg_q      <= chg_d;
            pending_q  <= pending_d;
            trig_q     <= trig_d;
            bar_q      <= bar_d;
        end
    end

    assign voice_trig      = trig_q;
    assign step_idx        = step_q;
    assign step_onehot     = onehot_q;
    assign bar_start       = bar_q;
    assign pattern_pending = pending_q;

endmodule

// File: tb/tb_pattern_step_sequencer.sv
// Scoreboard bench: stimulus queues expected pulses, a negedge monitor matches them.
module tb_pattern_step_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pattern;
    logic [7:0]  bpm;
    logic        run;
    logic [3:0]  voice_trig;
    logic [2:0]  step_idx;
    logic [7:0]  step_onehot;
    logic        bar_start;
    logic        pending;

    pattern_step_sequencer #(
        .CLK_HZ  (1000),
        .BPM_MIN (40),
        .BPM_MAX (240)
    ) dut (
        .clk_clk            (clk),
        .reset_reset_n      (rst_n),
        .pattern_new_signal (pattern),
        .tempo_bpm          (bpm),
        .run                (run),
        .voice_trig         (voice_trig),
        .step_idx           (step_idx),
        .step_onehot        (step_onehot),
        .bar_start          (bar_start),
        .pattern_pending    (pending)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [3:0] trig;
        logic       bar;
        logic [2:0] step;
    } ev_t;

    ev_t exp_q[$];
    ev_t ev;
    int  n_vec = 0;
    int  n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h want %0h", name, cyc, act, want);
        end
    endtask

    task automatic push_ev(input int c, input logic [3:0] t, input logic b, input logic [2:0] s);
        ev_t e;
        e.cyc  = c;
        e.trig = t;
        e.bar  = b;
        e.step = s;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Load a pattern while stopped and let it reach the active register.
    task automatic load_pat(input logic [31:0] p);
        pattern = p;
        repeat (4) @(negedge clk);
    endtask

    // Monitor: every pulse must match the head of the queue, and no expected pulse may be skipped.
    always @(negedge clk) begin
        if (rst_n) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                n_vec++;
                n_bad++;
                $display("FAIL missed_pulse: expected at cyc %0d, still unmatched at cyc %0d",
                         exp_q[0].cyc, cyc);
                void'(exp_q.pop_front());
            end
            if (voice_trig != 4'd0 || bar_start) begin
                if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_pulse @cyc %0d: got trig %b bar %b, want none",
                             cyc, voice_trig, bar_start);
                end else begin
                    ev = exp_q.pop_front();
                    chk("voice_trig", 32'(voice_trig), 32'(ev.trig));
                    chk("bar_start", 32'(bar_start), 32'(ev.bar));
                    chk("pulse_step_idx", 32'(step_idx), 32'(ev.step));
                end
            end
        end
    end

    int c0;
    int c1;
    int t240[9] = '{0, 63, 125, 188, 250, 313, 375, 438, 500};

    initial begin
        rst_n   = 1'b0;
        pattern = 32'd0;
        bpm     = 8'd120;
        run     = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_voice_trig", 32'(voice_trig), 32'd0);
        chk("reset_step_idx", 32'(step_idx), 32'd0);
        chk("reset_step_onehot", 32'(step_onehot), 32'h01);
        chk("reset_bar_start", 32'(bar_start), 32'd0);
        chk("reset_pending", 32'(pending), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic playback: voices 0 and 1 on step 0 only, 125-cycle steps.
        load_pat(32'h0000_0101);
        c0  = cyc;
        run = 1'b1;
        for (int k = 0; k <= 16; k += 8) push_ev(c0 + 1 + 125 * k, 4'b0011, 1'b1, 3'd0);
        wait_cyc(c0 + 1 + 375 + 10);
        chk("mid_step_idx", 32'(step_idx), 32'd3);
        chk("mid_step_onehot", 32'(step_onehot), 32'h08);
        wait_cyc(c0 + 1 + 2000 + 50);
        run = 1'b0;
        repeat (3) @(negedge clk);

        // Tempo clamp high: 255 plays as 240 -> 62/63-cycle steps, 500 cycles per bar.
        load_pat(32'h00FF_0000);
        bpm = 8'd255;
        c0  = cyc;
        run = 1'b1;
        for (int m = 0; m <= 8; m++) push_ev(c0 + 1 + t240[m], 4'b0100, (m % 8) == 0, 3'(m % 8));
        wait_cyc(c0 + 1 + 500 + 20);
        run = 1'b0;
        repeat (3) @(negedge clk);

        // Tempo clamp low: 10 plays as 40 -> 375-cycle steps.
        bpm = 8'd10;
        c0  = cyc;
        run = 1'b1;
        for (int m = 0; m <= 3; m++) push_ev(c0 + 1 + 375 * m, 4'b0100, m == 0, 3'(m));
        wait_cyc(c0 + 1 + 1125 + 20);
        run = 1'b0;
        repeat (3) @(negedge clk);

        // Deferred update: change during step 3, new pattern starts at the wrap.
        bpm = 8'd120;
        load_pat(32'h0000_0101);
        c0  = cyc;
        run = 1'b1;
        push_ev(c0 + 1, 4'b0011, 1'b1, 3'd0);
        for (int k = 8; k <= 10; k++) push_ev(c0 + 1 + 125 * k, 4'b1000, k == 8, 3'(k % 8));
        wait_cyc(c0 + 381);
        pattern = 32'hFF00_0000;
        @(negedge clk);
        chk("pending_after_1", 32'(pending), 32'd0);
        @(negedge clk);
        chk("pending_after_2", 32'(pending), 32'd1);
        wait_cyc(c0 + 1 + 875);
        chk("pending_step7", 32'(pending), 32'd1);
        wait_cyc(c0 + 1 + 1000);
        chk("pending_at_wrap", 32'(pending), 32'd0);
        wait_cyc(c0 + 1 + 1250 + 50);
        run = 1'b0;
        repeat (3) @(negedge clk);

        // Update landing on the wrap: old pattern plays a further bar.
        c0  = cyc;
        run = 1'b1;
        for (int k = 0; k < 16; k++) push_ev(c0 + 1 + 125 * k, 4'b1000, (k % 8) == 0, 3'(k % 8));
        push_ev(c0 + 1 + 2000, 4'b0001, 1'b1, 3'd0);
        wait_cyc(c0 + 999);
        pattern = 32'h0000_0001;
        wait_cyc(c0 + 1 + 1000);
        chk("pending_held_over_wrap", 32'(pending), 32'd1);
        wait_cyc(c0 + 1 + 2000);
        chk("pending_after_late_wrap", 32'(pending), 32'd0);
        wait_cyc(c0 + 1 + 2000 + 50);
        run = 1'b0;
        repeat (3) @(negedge clk);

        // Stop exactly on the step-6 tick, then restart.
        load_pat(32'hFFFF_FFFF);
        c0  = cyc;
        run = 1'b1;
        for (int k = 0; k <= 5; k++) push_ev(c0 + 1 + 125 * k, 4'b1111, k == 0, 3'(k));
        wait_cyc(c0 + 750);
        run = 1'b0;
        @(negedge clk);
        chk("stop_step_idx", 32'(step_idx), 32'd0);
        chk("stop_voice_trig", 32'(voice_trig), 32'd0);
        wait_cyc(c0 + 760);
        c1  = cyc;
        run = 1'b1;
        push_ev(c1 + 1, 4'b1111, 1'b1, 3'd0);
        push_ev(c1 + 126, 4'b1111, 1'b0, 3'd1);
        wait_cyc(c1 + 200);
        run = 1'b0;
        repeat (3) @(negedge clk);

        // Asynchronous reset while a trigger pulse is high.
        c0  = cyc;
        run = 1'b1;
        push_ev(c0 + 1, 4'b1111, 1'b1, 3'd0);
        wait_cyc(c0 + 1);
        chk("pre_reset_trig", 32'(voice_trig), 32'hF);
        #1 rst_n = 1'b0;
        #1;
        chk("async_voice_trig", 32'(voice_trig), 32'd0);
        chk("async_bar_start", 32'(bar_start), 32'd0);
        chk("async_step_idx", 32'(step_idx), 32'd0);
        chk("async_step_onehot", 32'(step_onehot), 32'h01);
        chk("async_pending", 32'(pending), 32'd0);
        run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(negedge clk);
        while (exp_q.size() > 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL leftover_pulse: expected at cyc %0d never matched", exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pattern_step_sequencer.md
# pattern_step_sequencer

- Consumes the 32-bit drum pattern word that the Nios II software writes out of `final_soc` on `pattern_new_signal`.
- Plays the pattern as a 4-voice × 8-step loop at a programmable tempo, one step per sixteenth note.
- Emits one-cycle trigger pulses that the downstream sample-playback voices consume, plus step position for LED display.
- Pattern updates are deferred to the next bar boundary so a loop is never torn mid-bar.

## Interface
Parameters:
- `CLK_HZ`, 50_000_000: system clock frequency; tick threshold `THRESH = CLK_HZ*15` (sixteenth note).
- `BPM_MIN`, 40: lowest accepted tempo.
- `BPM_MAX`, 240: highest accepted tempo.

Ports (one clock; reset is asynchronous and active-low):
- `clk_clk`  in  1  system clock.
- `reset_reset_n`  in  1  asynchronous active-low reset.
- `pattern_new_signal`  in  32  pattern word from SoC; bit `8*v+s` = voice v, step s.
- `tempo_bpm`  in  8  tempo in BPM; clamped to [BPM_MIN, BPM_MAX].
- `run`  in  1  level; 1 = play, 0 = stop.
- `voice_trig`  out  4  one-cycle trigger per voice.
- `step_idx`  out  3  current step, 0..7.
- `step_onehot`  out  8  one-hot of `step_idx`, for LEDs.
- `bar_start`  out  1  one-cycle pulse coincident with step-0 triggers.
- `pattern_pending`  out  1  a new pattern is waiting for the next bar.

## Operation
- **States:** STOPPED, RUNNING.
- **STOPPED:**
  - Accumulator is held at 0; `step_idx` = 0.
  - No triggers are emitted.
  - A changed input pattern is copied straight to the active register (no deferral).
- **STOPPED→RUNNING** on `run`=1:
  - Accumulator is cleared.
  - Step 0 fires immediately: `voice_trig` = active[7:0 columns of step 0], `bar_start` = 1.
- **RUNNING→STOPPED** on `run`=0:
  - Takes effect in the same cycle.
  - Any trigger due that cycle is suppressed.
  - `step_idx` returns to 0.
- **Tick generation (phase accumulator, RUNNING only):**
  - `bpm_c = clamp(tempo_bpm)`.
  - If `acc + bpm_c >= THRESH`: `acc <= acc + bpm_c - THRESH` and tick; else `acc <= acc + bpm_c`.
  - Accumulator width is `$clog2(THRESH + BPM_MAX)`.
  - Tempo changes apply on the next add; there is no accumulator reset.
- **On tick:**
  - `step_idx <= step_idx + 1`, wrapping 7→0.
  - Triggers for the new step fire in the same registered cycle as the index update.
- **Pattern capture:**
  - `shadow` samples `pattern_new_signal` every cycle.
  - In RUNNING, a change (`pattern_new_signal != shadow`) sets `pending` and stores the word in `next_pat`.
  - Later changes overwrite `next_pat`; the last value wins.
  - When the step wraps to 0, `active <= next_pat` and `pending` clears, before the step-0 triggers are evaluated. The new pattern therefore plays from its own step 0.
- **Simultaneous events:** a change arriving in the same cycle as a wrap is not applied at that wrap; it is applied at the following bar.
- **Reset values (async, all registers):**
  - `active`, `shadow`, `next_pat`, `acc` = 0.
  - `step_idx` = 0; `step_onehot` = 8'h01.
  - `voice_trig` = 0, `bar_start` = 0, `pending` = 0.
  - State = STOPPED.
- **Reset mid-bar:** outputs go to reset values immediately, and no trigger pulse completes.

## Timing
- All outputs are registered.
- `run` rising (sampled at edge N): `voice_trig`/`bar_start` high during cycle N+1, for exactly one cycle.
- Step period: average `THRESH/bpm_c` cycles, e.g. 6,250,000 cycles at 120 BPM / 50 MHz. Individual periods vary by ≤1 cycle and there is no long-term drift.
- Pattern change to `pending` high: 2 cycles (shadow compare, then register).
- `pattern_new_signal` is driven from the same clock domain (PIO), so there is no synchronizer.
- `voice_trig` bits for silent steps are 0. A step with all voices off still advances `step_idx`, with no pulse.

## Structure
- **Package `seq_pkg`:**
  - `NUM_VOICES`=4, `NUM_STEPS`=8.
  - State enum `seq_state_t`.
  - Function `pat_col(pat, step)` returning the 4-bit voice column.
- **Sub-module `tempo_tick_gen`:**
  - Contains the clamp, the phase accumulator, and the tick output.
  - Has an `enable` input; clears `acc` when not enabled.
- **Top module:** contains the FSM, pattern registers, step counter, and output registers.

## Test plan
Sim parameters: `CLK_HZ`=1000 (so `THRESH`=15000).
- **Basic playback:** pattern 32'h0000_0101, bpm=120, `run`↑.
  - Voice 0 pulses at steps 0 and 0… (bit 0).
  - Voice 1 pulses at step 0.
  - Ticks every 125 cycles; `bar_start` every 1000 cycles.
- **Tempo clamp:** bpm=255.
  - Period matches 240 BPM, i.e. 62/63 cycles alternating, 500 cycles per 8 steps.
  - bpm=10 gives 375-cycle steps.
- **Deferred update:** change the pattern to 32'hFF00_0000 at step 3.
  - `pending`=1 two cycles later.
  - Old pattern plays through step 7.
  - At the wrap, voice 3 fires on all steps and `pending`=0.
- **Update at wrap cycle:** pattern change exactly on the wrap cycle.
  - The new pattern becomes active one bar later.
- **Stop/restart:** `run`↓ at step 5 → triggers stop and `step_idx`=0. `run`↑ → step-0 triggers the next cycle.
- **Reset mid-run:** assert `reset_reset_n`=0 while `voice_trig`≠0 → all outputs reach reset values asynchronously, and `step_onehot`=8'h01.
